cmd_queue_loader: RTL and testbench
===================================

// Module: cmd_queue_loader
// PURPOSE
//  Producer end of the command queue: streams cmd_t words from a command ROM into the cmd fifo write port.
//  The issuer in top drains the same fifo via its read/empty handshake.
//  Replaces backdoor $readmemb preload of the fifo, so queue fill is exercised in RTL, including full backpressure.
// PARAMETERS
//  CMD_WIDTH   64   width of one command word ($bits(cmd_t) at instantiation)
//  ADDR_WIDTH  13   ROM word-address width (covers 4551-entry 64matvec program)
// PORTS
//  i_clk          in   1           clock
//  i_rst          in   1           synchronous reset, active-high
//  i_start        in   1           pulse: begin a transfer (ignored unless IDLE or DONE)
//  i_base_addr    in   ADDR_WIDTH  first ROM address, sampled on accepted i_start
//  i_count        in   ADDR_WIDTH+1  number of commands, sampled on accepted i_start
//  o_rom_rd       out  1           ROM read strobe
//  o_rom_addr     out  ADDR_WIDTH  ROM address
//  i_rom_data     in   CMD_WIDTH   ROM data, valid exactly 1 cycle after o_rom_rd
//  o_fifo_write   out  1           fifo write strobe (i_write of fifo)
//  o_fifo_data    out  CMD_WIDTH   fifo write data (i_data of fifo)
//  i_fifo_full    in   1           fifo full; write is accepted iff o_fifo_write && !i_fifo_full
//  o_busy         out  1           high in RUN or DRAIN
//  o_done         out  1           high in DONE; cleared by next accepted i_start or reset
//  o_pushed       out  ADDR_WIDTH+1  commands accepted by fifo in current transfer
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; skid buffer empty; in-flight flag clear. Reset mid-transfer aborts
//    immediately: no further rom reads or fifo writes from the following cycle.
//  - States: IDLE -> RUN on i_start (count>0); IDLE/DONE -> DONE on i_start with count=0 (o_done next cycle,
//    o_pushed=0). RUN -> DRAIN when last ROM read issued. DRAIN -> DONE when o_pushed==count. DONE -> RUN on i_start.
//  - ROM latency 1: data returning at cycle N+1 for read at N is captured into a 2-entry skid FIFO.
//  - Read issue rule: o_rom_rd=1 in RUN iff reads remaining>0 and (buffered + in-flight) < 2, counting an entry
//    leaving this cycle (write accepted). No ROM data ever dropped; no read stalls when fifo is never full.
//  - Write: o_fifo_write=1 whenever skid buffer non-empty; o_fifo_data = buffer head (order preserved).
//    Held stable while i_fifo_full=1. Steady-state throughput 1 cmd/cycle; first write 2 cycles after i_start.
//  - o_rom_addr = base + reads_issued; wraps modulo 2**ADDR_WIDTH (base+count may exceed top, addr wraps to 0).
//  - o_pushed increments once per accepted write; never exceeds sampled count.
//  - i_start while busy: ignored, no effect on counters or sampled params.
//  - i_fifo_full asserted the same cycle a write is presented: write not accepted, same data retried next cycle.
// CONFIGURATION
//  CMD_LOADER_CHECKSUM_EN defined: adds port o_checksum (out, CMD_WIDTH) = XOR of all words accepted by the
//    fifo in current transfer; cleared to 0 on reset and on accepted i_start; final at o_done.
//  Not defined: port absent, no checksum logic.
// TESTING
//  1 reset: hold i_rst 3 cycles mid-RUN -> all outputs 0 next cycle, no writes after; restart works.
//  2 base=0,count=8, full=0, ROM[i]=i -> 8 writes on consecutive cycles data 0..7, o_done, o_pushed=8.
//  3 count=6, i_fifo_full=1 cycles 3..7 after start -> o_fifo_data held, no loss/dup, order 0..5, <=2 reads ahead.
//  4 base=2**ADDR_WIDTH-2,count=4 -> o_rom_addr sequence 8190,8191,0,1; data in same order.
//  5 i_start count=0 -> o_done next cycle, no o_rom_rd/o_fifo_write; i_start during RUN ignored.
//  6 CMD_LOADER_CHECKSUM_EN, words 0xA,0x5,0xF -> o_checksum=0x0 at done; full=4551-cmd program ends o_pushed=4551.

Source files
------------

// File: rtl/cmd_queue_loader.sv
// rtl/cmd_queue_loader.sv - streams command words from a ROM into the command fifo write port
// Optional: CMD_LOADER_CHECKSUM_EN adds o_checksum (XOR of words accepted in the current transfer).
module cmd_queue_loader #(
   parameter int CMD_WIDTH  = 64,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH:0]   i_count,
   output logic                  o_rom_rd,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [CMD_WIDTH-1:0]  i_rom_data,
   output logic                  o_fifo_write,
   output logic [CMD_WIDTH-1:0]  o_fifo_data,
   input  logic                  i_fifo_full,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH:0]   o_pushed
`ifdef CMD_LOADER_CHECKSUM_EN
   ,
   output logic [CMD_WIDTH-1:0]  o_checksum
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   reads_q, reads_d;
   logic [ADDR_WIDTH:0]   pushed_q, pushed_d;
   logic                  inflight_q, inflight_d;
   logic [CMD_WIDTH-1:0]  buf_q [2];
   logic [CMD_WIDTH-1:0]  buf_d [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            cnt_q, cnt_d;

   logic       start_ok;
   logic       wr_acc;
   logic       rom_rd;
   logic [1:0] occ;

   // Occupancy after this cycle's pop: buffered words plus the word returning from the ROM.
   always_comb begin
      start_ok = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
      wr_acc   = (cnt_q != 2'd0) && !i_fifo_full;
      occ      = cnt_q + {1'b0, inflight_q} - {1'b0, wr_acc};
      rom_rd   = (state_q == S_RUN) && (reads_q != count_q) && (occ < 2'd2);
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      reads_d    = reads_q + {{ADDR_WIDTH{1'b0}}, rom_rd};
      pushed_d   = pushed_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      inflight_d = rom_rd;
      cnt_d      = occ;
      rd_ptr_d   = rd_ptr_q ^ wr_acc;
      wr_ptr_d   = wr_ptr_q ^ inflight_q;
      buf_d      = buf_q;
      if (inflight_q) begin
         buf_d[wr_ptr_q] = i_rom_data;
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               base_d   = i_base_addr;
               count_d  = i_count;
               reads_d  = '0;
               pushed_d = '0;
               state_d  = (i_count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (rom_rd && ((reads_q + 1'b1) == count_q)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pushed_q == count_q) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         reads_q    <= '0;
         pushed_q   <= '0;
         inflight_q <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         reads_q    <= reads_d;
         pushed_q   <= pushed_d;
         inflight_q <= inflight_d;
         buf_q      <= buf_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef CMD_LOADER_CHECKSUM_EN
   logic [CMD_WIDTH-1:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (start_ok) begin
         chk_d = '0;
      end else if (wr_acc) begin
         chk_d = chk_q ^ buf_q[rd_ptr_q];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign o_checksum = chk_q;
`endif

   assign o_rom_rd     = rom_rd;
   assign o_rom_addr   = base_q + reads_q[ADDR_WIDTH-1:0];
   assign o_fifo_write = (cnt_q != 2'd0);
   assign o_fifo_data  = buf_q[rd_ptr_q];
   assign o_busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign o_done       = (state_q == S_DONE);
   assign o_pushed     = pushed_q;

endmodule

// File: tb/tb_cmd_queue_loader.sv
// tb/tb_cmd_queue_loader.sv - scoreboard bench for cmd_queue_loader
// Optional: CMD_LOADER_CHECKSUM_EN enables the o_checksum checks.
module tb_cmd_queue_loader;

   localparam int CW = 64;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          rom_rd;
   logic [AW-1:0] rom_addr;
   logic [CW-1:0] rom_data;
   logic          fifo_write;
   logic [CW-1:0] fifo_data;
   logic          fifo_full;
   logic          busy;
   logic          done;
   logic [AW:0]   pushed;
`ifdef CMD_LOADER_CHECKSUM_EN
   logic [CW-1:0] checksum;
   logic [CW-1:0] exp_chk;
`endif

   cmd_queue_loader #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_base_addr  (base_addr),
      .i_count      (count),
      .o_rom_rd     (rom_rd),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_data),
      .o_fifo_write (fifo_write),
      .o_fifo_data  (fifo_data),
      .i_fifo_full  (fifo_full),
      .o_busy       (busy),
      .o_done       (done),
      .o_pushed     (pushed)
`ifdef CMD_LOADER_CHECKSUM_EN
      ,
      .o_checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   int            rom_mode;
   int            n_cmp;
   int            n_err;
   int            cyc;
   int            rd_cnt;
   int            wr_cnt;
   int            first_wr;
   int            last_wr;
   bit            hold_pend;
   logic [CW-1:0] hold_data;
   bit            check_ahead;
   bit            log_addr;
   logic [CW-1:0] exp_q[$];
   logic [AW-1:0] addr_q[$];

   function automatic logic [CW-1:0] rom_val(input logic [AW-1:0] a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
      case (rom_mode)
         1: rom_val = (a == 13'd0) ? 64'hA : (a == 13'd1) ? 64'h5 : 64'hF;
         2: rom_val = {h, 19'd0, a};
         default: rom_val = 64'(a);
      endcase
   endfunction

   always @(posedge clk) begin
      if (rom_rd) rom_data <= rom_val(rom_addr);
   end

   task automatic tick();
      logic [CW-1:0] exp;
      @(negedge clk);
      cyc++;
      if (hold_pend) begin
         n_cmp++;
         if (!fifo_write || fifo_data !== hold_data) begin
            n_err++;
            $display("FAIL hold_stable: write=%0b data=%h required write=1 data=%h", fifo_write, fifo_data, hold_data);
         end
      end
      hold_pend = 0;
      if (rom_rd) begin
         rd_cnt++;
         if (log_addr) addr_q.push_back(rom_addr);
      end
      if (fifo_write) begin
         if (fifo_full) begin
            hold_pend = 1;
            hold_data = fifo_data;
         end else begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL write_data: unexpected write data=%h required none", fifo_data);
            end else begin
               exp = exp_q.pop_front();
               if (fifo_data !== exp) begin
                  n_err++;
                  $display("FAIL write_data: got %h required %h", fifo_data, exp);
               end
            end
         end
      end
      if (check_ahead) begin
         n_cmp++;
         if (rd_cnt - wr_cnt > 2) begin
            n_err++;
            $display("FAIL reads_ahead: got %0d required <=2", rd_cnt - wr_cnt);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c, input bit accept);
      logic [AW-1:0] a;
      start     = 1'b1;
      base_addr = b;
      count     = c;
      if (accept) begin
`ifdef CMD_LOADER_CHECKSUM_EN
         exp_chk = '0;
`endif
         for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_q.push_back(rom_val(a));
`ifdef CMD_LOADER_CHECKSUM_EN
            exp_chk ^= rom_val(a);
`endif
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int n;
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL %s_timeout: done=%0b required 1 after %0d cycles", name, done, limit);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      n_cmp++;
      if ({rom_rd, fifo_write, busy, done} !== 4'b0) begin
         n_err++;
         $display("FAIL %s_strobes: rd/wr/busy/done=%b required 0000", name, {rom_rd, fifo_write, busy, done});
      end
      n_cmp++;
      if (rom_addr !== '0 || fifo_data !== '0 || pushed !== '0) begin
         n_err++;
         $display("FAIL %s_values: addr=%0d data=%h pushed=%0d required 0", name, rom_addr, fifo_data, pushed);
      end
`ifdef CMD_LOADER_CHECKSUM_EN
      n_cmp++;
      if (checksum !== '0) begin
         n_err++;
         $display("FAIL %s_checksum: got %h required 0", name, checksum);
      end
`endif
   endtask

   task automatic check_finish(input string name, input int exp_pushed);
      n_cmp++;
      if (pushed !== (AW+1)'(exp_pushed)) begin
         n_err++;
         $display("FAIL %s_pushed: got %0d required %0d", name, pushed, exp_pushed);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drained: %0d words missing required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      int rd0, wr0;
      rst = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset_init");
      rst = 1'b0;
      tick();
      rom_mode = 2;
      do_start(13'd100, 14'd20, 1);
      repeat (6) tick();
      rst = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset_mid");
      rst = 1'b0;
      exp_q.delete();
      hold_pend = 0;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      repeat (5) tick();
      n_cmp++;
      if (rd_cnt != rd0 || wr_cnt != wr0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_quiet: reads=%0d writes=%0d busy=%0b required 0 0 0", rd_cnt - rd0, wr_cnt - wr0, busy);
      end
      do_start(13'd0, 14'd4, 1);
      wait_done(50, "reset_restart");
      check_finish("reset_restart", 4);
   endtask

   task automatic test_stream();
      rom_mode = 0;
      first_wr = -1;
      wr_cnt   = 0;
      do_start(13'd0, 14'd8, 1);
      wait_done(50, "stream");
      check_finish("stream", 8);
      n_cmp++;
      if (wr_cnt != 8 || last_wr - first_wr != 7) begin
         n_err++;
         $display("FAIL stream_back_to_back: writes=%0d span=%0d required 8 7", wr_cnt, last_wr - first_wr);
      end
   endtask

   task automatic test_backpressure();
      rom_mode    = 0;
      rd_cnt      = 0;
      wr_cnt      = 0;
      check_ahead = 1;
      do_start(13'd0, 14'd6, 1);
      repeat (2) tick();
      fifo_full = 1'b1;
      repeat (5) tick();
      fifo_full = 1'b0;
      wait_done(50, "backpressure");
      check_ahead = 0;
      check_finish("backpressure", 6);
      n_cmp++;
      if (wr_cnt != 6 || rd_cnt != 6) begin
         n_err++;
         $display("FAIL backpressure_counts: reads=%0d writes=%0d required 6 6", rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_addr[4];
      exp_addr[0] = 13'd8190;
      exp_addr[1] = 13'd8191;
      exp_addr[2] = 13'd0;
      exp_addr[3] = 13'd1;
      rom_mode = 0;
      addr_q.delete();
      log_addr = 1;
      do_start(13'd8190, 14'd4, 1);
      wait_done(50, "wrap");
      log_addr = 0;
      check_finish("wrap", 4);
      n_cmp++;
      if (addr_q.size() != 4) begin
         n_err++;
         $display("FAIL wrap_reads: got %0d reads required 4", addr_q.size());
      end
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         n_cmp++;
         if (addr_q[i] !== exp_addr[i]) begin
            n_err++;
            $display("FAIL wrap_addr%0d: got %0d required %0d", i, addr_q[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_zero_and_ignore();
      int rd0, wr0;
      rom_mode = 0;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      do_start(13'd7, 14'd0, 1);
      n_cmp++;
      if (done !== 1'b1 || pushed !== '0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_count: done=%0b pushed=%0d busy=%0b required 1 0 0", done, pushed, busy);
      end
      repeat (3) tick();
      n_cmp++;
      if (rd_cnt != rd0 || wr_cnt != wr0) begin
         n_err++;
         $display("FAIL zero_count_quiet: reads=%0d writes=%0d required 0 0", rd_cnt - rd0, wr_cnt - wr0);
      end
      do_start(13'd40, 14'd5, 1);
      tick();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_run: got %0b required 1", busy);
      end
      do_start(13'd900, 14'd7, 0);
      wait_done(50, "ignore_start");
      check_finish("ignore_start", 5);
   endtask

   task automatic test_program();
      rom_mode = 1;
      do_start(13'd0, 14'd3, 1);
      wait_done(50, "words3");
      check_finish("words3", 3);
`ifdef CMD_LOADER_CHECKSUM_EN
      n_cmp++;
      if (checksum !== 64'h0) begin
         n_err++;
         $display("FAIL checksum3: got %h required 0", checksum);
      end
`endif
      rom_mode = 2;
      do_start(13'd0, 14'd4551, 1);
      while (!done && cyc < 40000) begin
         fifo_full = ($urandom_range(0, 3) == 0);
         tick();
      end
      fifo_full = 1'b0;
      wait_done(50, "program");
      check_finish("program", 4551);
`ifdef CMD_LOADER_CHECKSUM_EN
      n_cmp++;
      if (checksum !== exp_chk) begin
         n_err++;
         $display("FAIL checksum_prog: got %h required %h", checksum, exp_chk);
      end
`endif
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      cyc         = 0;
      rd_cnt      = 0;
      wr_cnt      = 0;
      first_wr    = -1;
      last_wr     = 0;
      hold_pend   = 0;
      hold_data   = '0;
      check_ahead = 0;
      log_addr    = 0;
      rom_mode    = 0;
      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      count       = '0;
      fifo_full   = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_wrap();
      test_zero_and_ignore();
      test_program();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
